// File: rtl/execute_muldiv_unit_pkg.sv
// Shared definitions for the execute stage and its iterative multiply/divide datapath:
// ALU_Operation encodings, 6-bit ALU control codes, M-extension funct3 codes, FSM states,
// and the base-ALU decode function.
package execute_muldiv_unit_pkg;

  // ALU_Operation encodings from decode
  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_I   = 3'b001;
  localparam logic [2:0] OP_BR  = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // ALU_Control codes
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_BEQ  = 6'd10;
  localparam logic [5:0] ALU_BNE  = 6'd11;
  localparam logic [5:0] ALU_BLT  = 6'd12;
  localparam logic [5:0] ALU_BGE  = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;
  localparam logic [5:0] ALU_LINK = 6'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  // Base-ALU control decode; SUB only exists for R-type, SRA/SRAI keyed on funct7
  function automatic logic [5:0] alu_decode(input logic [2:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic alt;
    alt = (f7 == F7_ALT);
    alu_decode = ALU_ADD;
    case (op)
      OP_R, OP_I: begin
        case (f3)
          3'b000: alu_decode = (op == OP_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001: alu_decode = ALU_SLL;
          3'b010: alu_decode = ALU_SLT;
          3'b011: alu_decode = ALU_SLTU;
          3'b100: alu_decode = ALU_XOR;
          3'b101: alu_decode = alt ? ALU_SRA : ALU_SRL;
          3'b110: alu_decode = ALU_OR;
          3'b111: alu_decode = ALU_AND;
        endcase
      end
      OP_BR: begin
        case (f3)
          3'b000:  alu_decode = ALU_BEQ;
          3'b001:  alu_decode = ALU_BNE;
          3'b100:  alu_decode = ALU_BLT;
          3'b101:  alu_decode = ALU_BGE;
          3'b110:  alu_decode = ALU_BLTU;
          3'b111:  alu_decode = ALU_BGEU;
          default: alu_decode = ALU_ADD;
        endcase
      end
      OP_JMP:  alu_decode = ALU_LINK;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_muldiv_iterative.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) datapath.
// Ports: clk, rst_n; start_i loads operands and sign info from funct3_i/a_i/b_i;
// step_i advances one bit; done_c_o flags the final step in the current cycle and
// result_c_o carries the sign-corrected result of that step.
// Optional macro EXEC_EARLY_TERM_EN: multiply ends once the remaining multiplier bits are 0.
import execute_muldiv_unit_pkg::*;

module execute_muldiv_unit_muldiv_iterative #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_c_o,
  output logic [DATA_WIDTH-1:0] result_c_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  // x: multiplier (shifts right) or dividend/quotient (shifts left)
  // y: shifted multiplicand or divisor; acc: product or partial remainder
  logic [2:0]     op_q;
  logic           neg_q, rneg_q;
  logic [2*W-1:0] acc_q, y_q;
  logic [W-1:0]   x_q;
  logic [CW-1:0]  cnt_q;

  logic           sa_c, sb_c, a_neg_c, b_neg_c;
  logic [W-1:0]   ma_c, mb_c;

  // Operand magnitudes according to the signedness of the op
  always_comb begin
    sa_c = 1'b0;
    sb_c = 1'b0;
    case (funct3_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin sa_c = 1'b1; sb_c = 1'b1; end
      F3_MULHSU:                       sa_c = 1'b1;
      default:                         ;
    endcase
    a_neg_c = sa_c & a_i[W-1];
    b_neg_c = sb_c & b_i[W-1];
    ma_c    = a_neg_c ? -a_i : a_i;
    mb_c    = b_neg_c ? -b_i : b_i;
  end

  logic           is_div_c;
  logic [2*W-1:0] acc_n, y_n, prod_c;
  logic [W-1:0]   x_n, quo_c, rem_c;
  logic [W:0]     r_sh_c, diff_c;

  // One iteration step plus final sign correction / half select
  always_comb begin
    is_div_c = op_q[2];
    r_sh_c   = {acc_q[W-1:0], x_q[W-1]};
    diff_c   = r_sh_c - {1'b0, y_q[W-1:0]};
    if (is_div_c) begin
      // diff_c[W] set means the trial subtraction went negative: restore
      acc_n = {{W{1'b0}}, diff_c[W] ? r_sh_c[W-1:0] : diff_c[W-1:0]};
      x_n   = {x_q[W-2:0], ~diff_c[W]};
      y_n   = y_q;
    end else begin
      acc_n = x_q[0] ? acc_q + y_q : acc_q;
      x_n   = x_q >> 1;
      y_n   = y_q << 1;
    end
    prod_c = neg_q ? -acc_n : acc_n;
    quo_c  = neg_q ? -x_n : x_n;
    rem_c  = rneg_q ? -acc_n[W-1:0] : acc_n[W-1:0];
    if (is_div_c) result_c_o = op_q[1] ? rem_c : quo_c;
    else          result_c_o = (op_q[1:0] == 2'b00) ? prod_c[W-1:0] : prod_c[2*W-1:W];
    done_c_o = (cnt_q == CW'(W-1));
`ifdef EXEC_EARLY_TERM_EN
    if (!is_div_c && x_n == '0) done_c_o = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      acc_q  <= '0;
      y_q    <= '0;
      x_q    <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      op_q   <= funct3_i;
      neg_q  <= a_neg_c ^ b_neg_c;
      rneg_q <= a_neg_c;
      acc_q  <= '0;
      cnt_q  <= '0;
      if (funct3_i[2]) begin
        x_q <= ma_c;
        y_q <= {{W{1'b0}}, mb_c};
      end else begin
        x_q <= mb_c;
        y_q <= {{W{1'b0}}, ma_c};
      end
    end else if (step_i) begin
      acc_q <= acc_n;
      x_q   <= x_n;
      y_q   <= y_n;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute stage: base ALU, branch compare, JALR target and RV32M multiply/divide with
// valid/ready handshakes. Holds the FSM (IDLE/MUL/DIV/DONE), handshake and output registers.
// Ports: clock, reset (async active-low), flush; in_valid/in_ready with ALU_Operation, funct3,
// funct7, PC, ALU_ASrc, ALU_BSrc, branch_op, regRead_1/2, extend; out_valid/out_ready with
// ALU_result, zero, branch, JALR_target; busy.
// Optional macro EXEC_EARLY_TERM_EN: early-terminating multiply (results unchanged).
import execute_muldiv_unit_pkg::*;

module execute_muldiv_unit #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              ALU_Operation,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [1:0]              ALU_ASrc,
  input  logic                    ALU_BSrc,
  input  logic                    branch_op,
  input  logic [DATA_WIDTH-1:0]   regRead_1,
  input  logic [DATA_WIDTH-1:0]   regRead_2,
  input  logic [DATA_WIDTH-1:0]   extend,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic                    zero,
  output logic                    branch,
  output logic [ADDRESS_BITS-1:0] JALR_target,
  output logic                    busy
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  // CORE only labels reports; referenced here so it is not flagged as dangling
  logic unused_core_c;
  assign unused_core_c = (CORE != 0);

  state_e                  state_q, state_d;
  logic [W-1:0]            result_q, result_d;
  logic                    zero_q, zero_d, branch_q, branch_d;
  logic [ADDRESS_BITS-1:0] jalr_q, jalr_d;
  logic                    out_valid_q, busy_q, in_ready_q;

  logic [W-1:0]            op_a_c, op_b_c, alu_c, special_c, md_result_c;
  logic [5:0]              ctrl_c;
  logic                    cmp_c, md_done_c, md_start_c, md_step_c;
  logic                    is_m_c, is_div_c, div_zero_c, div_ovf_c;
  logic [ADDRESS_BITS-1:0] jalr_sum_c, jalr_c;
  logic [SHW-1:0]          shamt_c;

  // Operand selection and base ALU
  always_comb begin
    case (ALU_ASrc)
      2'b01:   op_a_c = W'(PC);
      2'b10:   op_a_c = W'(PC) + W'(4);
      default: op_a_c = regRead_1;
    endcase
    op_b_c  = ALU_BSrc ? extend : regRead_2;
    shamt_c = op_b_c[SHW-1:0];
    ctrl_c  = alu_decode(ALU_Operation, funct3, funct7);
    cmp_c   = 1'b0;
    alu_c   = op_a_c + op_b_c;
    case (ctrl_c)
      ALU_SUB:  alu_c = op_a_c - op_b_c;
      ALU_SLL:  alu_c = op_a_c << shamt_c;
      ALU_SLT:  alu_c = W'($signed(op_a_c) < $signed(op_b_c));
      ALU_SLTU: alu_c = W'(op_a_c < op_b_c);
      ALU_XOR:  alu_c = op_a_c ^ op_b_c;
      ALU_SRL:  alu_c = op_a_c >> shamt_c;
      ALU_SRA:  alu_c = $unsigned($signed(op_a_c) >>> shamt_c);
      ALU_OR:   alu_c = op_a_c | op_b_c;
      ALU_AND:  alu_c = op_a_c & op_b_c;
      ALU_BEQ:  begin cmp_c = (op_a_c == op_b_c);                   alu_c = W'(cmp_c); end
      ALU_BNE:  begin cmp_c = (op_a_c != op_b_c);                   alu_c = W'(cmp_c); end
      ALU_BLT:  begin cmp_c = ($signed(op_a_c) < $signed(op_b_c));  alu_c = W'(cmp_c); end
      ALU_BGE:  begin cmp_c = ($signed(op_a_c) >= $signed(op_b_c)); alu_c = W'(cmp_c); end
      ALU_BLTU: begin cmp_c = (op_a_c < op_b_c);                    alu_c = W'(cmp_c); end
      ALU_BGEU: begin cmp_c = (op_a_c >= op_b_c);                   alu_c = W'(cmp_c); end
      ALU_LINK: alu_c = W'(PC) + W'(4);
      default:  ;
    endcase
  end

  assign jalr_sum_c = ADDRESS_BITS'(regRead_1 + extend);
  assign jalr_c     = {jalr_sum_c[ADDRESS_BITS-1:1], 1'b0};

  // M-op classification; divide-by-zero and MIN/-1 bypass the iterative datapath
  assign is_m_c     = (ALU_Operation == OP_R) && (funct7 == F7_MULDIV);
  assign is_div_c   = funct3[2];
  assign div_zero_c = (op_b_c == '0);
  assign div_ovf_c  = ~funct3[0] && (op_a_c == MIN_VAL) && (op_b_c == '1);
  assign special_c  = div_zero_c ? (funct3[1] ? op_a_c : '1) : (funct3[1] ? '0 : MIN_VAL);

  execute_muldiv_unit_muldiv_iterative #(.DATA_WIDTH(DATA_WIDTH)) u_md (
    .clk       (clock),
    .rst_n     (reset),
    .start_i   (md_start_c),
    .step_i    (md_step_c),
    .funct3_i  (funct3),
    .a_i       (op_a_c),
    .b_i       (op_b_c),
    .done_c_o  (md_done_c),
    .result_c_o(md_result_c)
  );

  // Next state and result register updates; flush overrides everything
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    branch_d   = branch_q;
    jalr_d     = jalr_q;
    md_start_c = 1'b0;
    md_step_c  = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            jalr_d = jalr_c;
            if (is_m_c) begin
              if (is_div_c && (div_zero_c || div_ovf_c)) begin
                result_d = special_c;
                zero_d   = (special_c == '0);
                branch_d = 1'b0;
                state_d  = ST_DONE;
              end else begin
                md_start_c = 1'b1;
                state_d    = is_div_c ? ST_DIV : ST_MUL;
              end
            end else begin
              result_d = alu_c;
              zero_d   = (alu_c == '0);
              branch_d = branch_op & cmp_c;
              state_d  = ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          md_step_c = 1'b1;
          if (md_done_c) begin
            result_d = md_result_c;
            zero_d   = (md_result_c == '0);
            branch_d = 1'b0;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      jalr_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      branch_q    <= branch_d;
      jalr_q      <= jalr_d;
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign ALU_result  = result_q;
  assign zero        = zero_q;
  assign branch      = branch_q;
  assign JALR_target = jalr_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed self-checking bench for execute_muldiv_unit (DATA_WIDTH 32, ADDRESS_BITS 20).
module tb_execute_muldiv_unit;

`ifdef EXEC_EARLY_TERM_EN
  localparam int L_MULH = 3;
  localparam int L_MUL  = 4;
`else
  localparam int L_MULH = 33;
  localparam int L_MUL  = 33;
`endif

  logic        clock, reset, flush, in_valid, in_ready;
  logic [2:0]  ALU_Operation, funct3;
  logic [6:0]  funct7;
  logic [19:0] PC;
  logic [1:0]  ALU_ASrc;
  logic        ALU_BSrc, branch_op;
  logic [31:0] regRead_1, regRead_2, extend;
  logic        out_valid, out_ready;
  logic [31:0] ALU_result;
  logic        zero, branch;
  logic [19:0] JALR_target;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  execute_muldiv_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Operation(ALU_Operation), .funct3(funct3), .funct7(funct7), .PC(PC),
    .ALU_ASrc(ALU_ASrc), .ALU_BSrc(ALU_BSrc), .branch_op(branch_op),
    .regRead_1(regRead_1), .regRead_2(regRead_2), .extend(extend),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
    .zero(zero), .branch(branch), .JALR_target(JALR_target), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
    ALU_Operation = aop; funct3 = f3; funct7 = f7;
    regRead_1 = a; regRead_2 = b; extend = 32'd0;
    ALU_ASrc = 2'b00; ALU_BSrc = 1'b0; branch_op = 1'b0;
  endtask

  // Present the op, count edges until out_valid (bounded), check latency
  task automatic issue(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    do begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic run(input string tag, input int exp_lat, input logic [31:0] exp_res);
    issue(tag, exp_lat);
    chk({tag, "_result"}, 64'(ALU_result), 64'(exp_res));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'd0));
    consume(tag);
  endtask

  initial begin
    logic rose;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; PC = '0;
    set_op(3'b000, 3'b000, 7'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(ALU_result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_branch", 64'(branch), 64'd0);
    chk("rst_jalr", 64'(JALR_target), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Base ALU
    set_op(3'b000, 3'b000, 7'd0, 32'd5, 32'd7);                 run("add", 1, 32'd12);
    set_op(3'b000, 3'b000, 7'b0100000, 32'd5, 32'd5);           run("sub", 1, 32'd0);
    set_op(3'b000, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'd1);         run("slt", 1, 32'd1);
    set_op(3'b000, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);   run("sra", 1, 32'hF800_0000);
    set_op(3'b001, 3'b000, 7'b0100000, 32'd10, 32'd0);
    ALU_BSrc = 1'b1; extend = 32'hFFFF_FFFD;                    run("addi", 1, 32'd7);

    // Multiply
    set_op(3'b000, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'd3);   run("mulh", L_MULH, 32'hFFFF_FFFF);
    set_op(3'b000, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'd3);   run("mulhu", L_MULH, 32'd2);
    set_op(3'b000, 3'b000, 7'b0000001, 32'd7, 32'hFFFF_FFFA);   run("mul", L_MUL, 32'hFFFF_FFD6);

    // Divide
    set_op(3'b000, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2);   run("div", 33, 32'hFFFF_FFFD);
    set_op(3'b000, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2);   run("rem", 33, 32'hFFFF_FFFF);
    set_op(3'b000, 3'b101, 7'b0000001, 32'd100, 32'd7);         run("divu", 33, 32'd14);
    set_op(3'b000, 3'b111, 7'b0000001, 32'd100, 32'd7);         run("remu", 33, 32'd2);
    set_op(3'b000, 3'b101, 7'b0000001, 32'd7, 32'd0);           run("divu_by0", 1, 32'hFFFF_FFFF);
    set_op(3'b000, 3'b111, 7'b0000001, 32'd7, 32'd0);           run("remu_by0", 1, 32'd7);
    set_op(3'b000, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_ovf", 1, 32'h8000_0000);
    set_op(3'b000, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf", 1, 32'd0);

    // DONE holds while out_ready is low, even with a new op offered
    set_op(3'b000, 3'b000, 7'd0, 32'd1, 32'd2);
    issue("hold", 1);
    set_op(3'b000, 3'b000, 7'd0, 32'd100, 32'd200);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("hold_result", 64'(ALU_result), 64'd3);
      chk("hold_flags", {60'd0, out_valid, in_ready, busy, zero}, 64'b1010);
    end
    in_valid = 1'b0;
    consume("hold");

    // Flush mid-multiply: back to IDLE, no result ever signalled, result kept
    set_op(3'b000, 3'b011, 7'b0000001, 32'd3, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("mul_busy", {62'd0, busy, in_ready}, 64'b10);
    repeat (4) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_state", {61'd0, busy, in_ready, out_valid}, 64'b010);
    chk("flush_result", 64'(ALU_result), 64'd3);
    rose = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid) rose = 1'b1;
    end
    chk("flush_no_valid", 64'(rose), 64'd0);

    // Branches
    set_op(3'b010, 3'b000, 7'd0, 32'd4, 32'd4);   branch_op = 1'b1;
    issue("beq", 1);
    chk("beq_branch", 64'(branch), 64'd1);
    consume("beq");
    set_op(3'b010, 3'b001, 7'd0, 32'd4, 32'd4);   branch_op = 1'b1;
    issue("bne", 1);
    chk("bne_branch", {62'd0, branch, zero}, 64'b01);
    consume("bne");
    set_op(3'b010, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1); branch_op = 1'b1;
    issue("blt", 1);
    chk("blt_branch", 64'(branch), 64'd1);
    consume("blt");

    // JALR: target (0x101+2)&~1, link PC+4
    set_op(3'b011, 3'b000, 7'd0, 32'h101, 32'd0);
    ALU_BSrc = 1'b1; extend = 32'd2; ALU_ASrc = 2'b10; PC = 20'h01000;
    issue("jalr", 1);
    chk("jalr_target", 64'(JALR_target), 64'h102);
    chk("jalr_link", 64'(ALU_result), 64'h1004);
    chk("jalr_branch", 64'(branch), 64'd0);
    consume("jalr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
